// File: rtl/uart_buffered.sv
// Buffered UART: TX/RX FIFOs around bit-serial engines with per-frame latched baud/parity/stop config.
// TX line goes low the edge after the FIFO becomes non-empty; a full TX FIFO refuses pushes, a full RX FIFO drops frames.

module uart_buffered_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_en,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end

    // Extra pointer MSB distinguishes full from empty so every entry is usable.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_dat = mem[rd_ptr[AW-1:0]];
endmodule

module uart_buffered #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [1:0]        parity_type,
    input  logic              stop_bits,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    input  logic              rx_ready,
    input  logic              data_rx,
    output logic              data_tx,
    output logic              tx_active_flag,
    output logic              rx_active_flag,
    output logic [2:0]        error_flag,
    input  logic              error_clr
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DIV_W-1:0] div_eff;
    assign div_eff = (baud_div < DIV_W'(4)) ? DIV_W'(4) : baud_div;

    // ---------------- TX ----------------
    state_t            tx_state, tx_next;
    logic [DIV_W-1:0]  tx_cnt, tx_div;
    logic [3:0]        tx_bit;
    logic [DATA_W-1:0] tx_shift, tx_head;
    logic              tx_par, tx_stop2, tx_load, tx_tick, tx_full, tx_empty, tx_push;
    logic [1:0]        tx_ptype;

    assign tx_push  = tx_valid && !tx_full;
    assign tx_ready = !tx_full;
    assign tx_tick  = (tx_cnt == tx_div - 1'b1);

    uart_buffered_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .wr_en(tx_push), .wr_dat(tx_data),
        .rd_en(tx_load), .rd_dat(tx_head), .full(tx_full), .empty(tx_empty)
    );

    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        data_tx = 1'b1;
        case (tx_state)
            IDLE: if (!tx_empty) begin
                tx_next = START;
                tx_load = 1'b1;
            end
            START: begin
                data_tx = 1'b0;
                if (tx_tick) tx_next = DATA;
            end
            DATA: begin
                data_tx = tx_shift[0];
                if (tx_tick && tx_bit == 4'(DATA_W - 1)) tx_next = (^tx_ptype) ? PARITY : STOP;
            end
            PARITY: begin
                data_tx = tx_par;
                if (tx_tick) tx_next = STOP;
            end
            STOP: if (tx_tick && tx_bit == (tx_stop2 ? 4'd1 : 4'd0)) begin
                // Back-to-back frames: reload straight into START without an idle bit.
                if (!tx_empty) begin
                    tx_next = START;
                    tx_load = 1'b1;
                end else begin
                    tx_next = IDLE;
                end
            end
            default: tx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_div   <= DIV_W'(4);
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_ptype <= 2'b00;
            tx_stop2 <= 1'b0;
        end else begin
            tx_state <= tx_next;
            if (tx_load) begin
                tx_shift <= tx_head;
                tx_par   <= (^tx_head) ^ parity_type[0];
                tx_ptype <= parity_type;
                tx_stop2 <= stop_bits;
                tx_div   <= div_eff;
                tx_cnt   <= '0;
                tx_bit   <= '0;
            end else if (tx_state != IDLE) begin
                if (tx_tick) begin
                    tx_cnt <= '0;
                    tx_bit <= (tx_next != tx_state) ? 4'd0 : tx_bit + 1'b1;
                    if (tx_state == DATA) tx_shift <= tx_shift >> 1;
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end
        end
    end

    assign tx_active_flag = (tx_state != IDLE);

    // ---------------- RX ----------------
    state_t            rx_state, rx_next;
    logic [1:0]        rx_sync;
    logic              rx_s, rx_tick, rx_start, rx_done, par_err, frm_err;
    logic [DIV_W-1:0]  rx_cnt, rx_div;
    logic [3:0]        rx_bit;
    logic [DATA_W-1:0] rx_shift, rx_word, rx_head;
    logic [1:0]        rx_ptype;
    logic              rx_push, rx_full, rx_empty, rx_pop, rx_wr, overrun;

    assign rx_s    = rx_sync[1];
    assign rx_tick = (rx_state == START) ? (rx_cnt == (rx_div >> 1)) : (rx_cnt == rx_div - 1'b1);

    always_comb begin
        rx_next  = rx_state;
        rx_start = 1'b0;
        rx_done  = 1'b0;
        par_err  = 1'b0;
        frm_err  = 1'b0;
        case (rx_state)
            IDLE: if (!rx_s) begin
                rx_next  = START;
                rx_start = 1'b1;
            end
            START: if (rx_tick) rx_next = rx_s ? IDLE : DATA;
            DATA: if (rx_tick && rx_bit == 4'(DATA_W - 1)) rx_next = (^rx_ptype) ? PARITY : STOP;
            PARITY: if (rx_tick) begin
                rx_next = STOP;
                par_err = (rx_s != ((^rx_shift) ^ rx_ptype[0]));
            end
            STOP: if (rx_tick) begin
                rx_next = IDLE;
                rx_done = 1'b1;
                frm_err = !rx_s;
            end
            default: rx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync  <= 2'b11;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_div   <= DIV_W'(4);
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_ptype <= 2'b00;
            rx_push  <= 1'b0;
            rx_word  <= '0;
        end else begin
            rx_sync  <= {rx_sync[0], data_rx};
            rx_state <= rx_next;
            rx_push  <= rx_done;
            if (rx_done) rx_word <= rx_shift;
            if (rx_start) begin
                rx_cnt   <= '0;
                rx_bit   <= '0;
                rx_div   <= div_eff;
                rx_ptype <= parity_type;
            end else if (rx_state != IDLE) begin
                if (rx_tick) begin
                    rx_cnt <= '0;
                    rx_bit <= (rx_next != rx_state) ? 4'd0 : rx_bit + 1'b1;
                    if (rx_state == DATA) rx_shift <= {rx_s, rx_shift[DATA_W-1:1]};
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
            end
        end
    end

    // A same-cycle pop frees the slot, so a full FIFO can still take the word.
    assign rx_pop  = rx_ready && !rx_empty;
    assign rx_wr   = rx_push && (!rx_full || rx_pop);
    assign overrun = rx_push && rx_full && !rx_pop;

    uart_buffered_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .wr_en(rx_wr), .wr_dat(rx_word),
        .rd_en(rx_pop), .rd_dat(rx_head), .full(rx_full), .empty(rx_empty)
    );

    assign rx_valid       = !rx_empty;
    assign rx_data        = rx_empty ? '0 : rx_head;
    assign rx_active_flag = (rx_state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) error_flag <= 3'b000;
        else        error_flag <= (error_flag & {3{~error_clr}}) | {overrun, frm_err, par_err};
    end
endmodule

// File: doc/uart_buffered.md
UART_BUFFERED -- requirements
Module: uart_buffered

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL provide parameter FIFO_DEPTH, default 16, entries per TX and per RX FIFO (power of 2, >=2).
REQ-003 SHALL provide parameter DIV_W, default 16, width of baud_div.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port baud_div  input  DIV_W  clk cycles per bit; values <4 treated as 4.
REQ-007 SHALL have port parity_type  input  2  00 none, 01 odd, 10 even, 11 none.
REQ-008 SHALL have port stop_bits  input  1  0 = one stop bit, 1 = two.
REQ-009 SHALL have ports tx_valid in 1, tx_data in DATA_W, tx_ready out 1: TX FIFO push; tx_ready = TX FIFO not full.
REQ-010 SHALL have ports rx_valid out 1, rx_data out DATA_W, rx_ready in 1: RX FIFO pop; rx_data = head word, valid while rx_valid.
REQ-011 SHALL have ports data_rx in 1, data_tx out 1: serial line, idle high.
REQ-012 SHALL have ports tx_active_flag out 1, rx_active_flag out 1: engine not IDLE.
REQ-013 SHALL have port error_flag  output  3  {overrun, frame, parity}, sticky.
REQ-014 SHALL have port error_clr  input  1  one-cycle pulse clears error_flag.

Function
REQ-015 Push SHALL occur on tx_valid&tx_ready; pop on rx_valid&rx_ready; full TX FIFO SHALL ignore tx_valid (no push, even with same-cycle engine pop).
REQ-016 TX FSM SHALL use states IDLE, START, DATA, PARITY, STOP; frame = start(0), DATA_W bits LSB first, optional parity, 1 or 2 stop(1).
REQ-017 TX SHALL leave IDLE when FIFO non-empty: pops head and drives data_tx=0 from the edge after the push that made FIFO non-empty.
REQ-018 Each TX bit SHALL last exactly baud_div cycles (after <4 clamp); PARITY skipped when parity_type is 00/11.
REQ-019 Parity bit SHALL be XOR of data bits (even) or its inverse (odd).
REQ-020 baud_div, parity_type, stop_bits SHALL be latched per engine at frame start; changes mid-frame SHALL not affect current frame.
REQ-021 After last stop bit TX SHALL start the next frame with no idle gap if FIFO non-empty, else return to IDLE.
REQ-022 data_rx SHALL pass a 2-flop synchroniser; all RX decisions use the synchronised value.
REQ-023 RX FSM SHALL use states IDLE, START, DATA, PARITY, STOP; low in IDLE enters START.
REQ-024 RX SHALL resample at baud_div/2 (floor) cycles into START; high = false start, back to IDLE, no error, no push.
REQ-025 RX SHALL then sample each DATA/PARITY/first-stop bit every baud_div cycles; second stop bit not checked.
REQ-026 Parity mismatch SHALL set error_flag[0]; low stop sample SHALL set error_flag[1]; word SHALL still be pushed.
REQ-027 RX push SHALL occur the cycle after the stop sample; if RX FIFO full and not popped that cycle, word dropped and error_flag[2] set; full FIFO with same-cycle pop SHALL accept the word.
REQ-028 After the stop sample RX SHALL return to IDLE and may detect a new start bit the next cycle.
REQ-029 error_flag bits SHALL set/hold until error_clr; a set event in the same cycle as error_clr SHALL win.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; all FIFO_DEPTH entries usable.

Reset
REQ-031 reset low SHALL asynchronously clear FSMs to IDLE, counters, FIFOs empty, synchroniser to 1, error_flag=000.
REQ-032 During/after reset: data_tx=1, tx_ready=1, rx_valid=0, rx_data=0, tx/rx_active_flag=0; reset mid-frame SHALL abort the frame, no push.

Verification
REQ-033 baud_div=4, parity 10, stop 0, push 8'hA5 -> data_tx 0,1,0,1,0,0,1,0,1,0(parity),1, each 4 cycles, low starts cycle after push.
REQ-034 Loopback data_tx->data_rx, baud_div=10, parity 01, stop 1, push 16 words -> identical 16 words on rx_data in order, error_flag=000.
REQ-035 RX FIFO full (16), no pops, one more frame -> word dropped, error_flag=100; error_clr -> 000.
REQ-036 Inject wrong parity bit and low stop bit -> word pushed, error_flag=011.
REQ-037 Low glitch shorter than baud_div/2 on data_rx -> no push, no error, rx_active_flag back to 0.
REQ-038 Assert reset mid-TX-DATA -> data_tx=1 immediately, FIFOs empty, tx_ready=1.
